// File: rtl/mdu_seq_ctrl_if.sv
// Issue-side and writeback-side handshake bundle of the RV32M execute unit.
// master = issue/writeback pipeline, slave = the execute unit.
`timescale 1ns/1ps
interface mdu_seq_ctrl_if #(
    parameter int XLEN = 32
);
    logic            start_valid;
    logic            start_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            result_valid;
    logic            result_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output start_valid, funct3, rs1, rs2, flush, result_ready,
        input  start_ready, result_valid, result, busy
    );

    modport slave (
        input  start_valid, funct3, rs1, rs2, flush, result_ready,
        output start_ready, result_valid, result, busy
    );
endinterface

// File: rtl/mdu_seq_ctrl.sv
// RV32M execute unit: one-cycle multiply through an external array multiplier,
// bit-serial restoring divide, and a single result slot with valid/ready back-pressure.
`timescale 1ns/1ps
module mdu_seq_ctrl #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    mdu_seq_ctrl_if.slave     bus,
    output logic [XLEN-1:0]   mul_a,
    output logic [XLEN-1:0]   mul_b,
    output logic [1:0]        mul_sn,
    input  logic [2*XLEN-1:0] mul_p
);
    localparam int                     CW     = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0]        ONE    = XLEN'(1);
    localparam logic [CW-1:0]          LAST   = CW'(XLEN - 1);
    localparam logic signed [XLEN-1:0] MIN_S  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic signed [XLEN-1:0] NEG1_S = '1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] mul_a_q, mul_a_d;
    logic [XLEN-1:0] mul_b_q, mul_b_d;
    logic [1:0]      mul_sn_q, mul_sn_d;
    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_q_q, neg_q_d;
    logic            neg_r_q, neg_r_d;
    logic            fast_q, fast_d;

    logic signed [XLEN-1:0] rs1_s, rs2_s;
    logic                   is_idle, accept;
    logic                   op_is_div, div_signed, div_by_zero, div_ovf, div_fast;
    logic [XLEN:0]          trial;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + ONE) : v;
    endfunction

    // Multiplier sign selects; 01 (A unsigned, B signed) has no RV32M user.
    function automatic logic [1:0] sn_for(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001: return 2'b11;
            3'b010:         return 2'b10;
            default:        return 2'b00;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] fast_result(input logic [2:0] f3,
                                                    input logic [XLEN-1:0] a,
                                                    input logic zero);
        if (zero) begin
            return f3[1] ? a : '1;
        end
        return f3[1] ? '0 : a;
    endfunction

    assign rs1_s       = $signed(bus.rs1);
    assign rs2_s       = $signed(bus.rs2);
    assign is_idle     = (state_q == S_IDLE);
    assign accept      = is_idle && bus.start_valid && !bus.flush;
    assign op_is_div   = bus.funct3[2];
    assign div_signed  = op_is_div && !bus.funct3[0];
    assign div_by_zero = op_is_div && (bus.rs2 == '0);
    assign div_ovf     = div_signed && (rs1_s == MIN_S) && (rs2_s == NEG1_S);
    assign div_fast    = div_by_zero || div_ovf;

    // Trial subtraction of one restoring step; the top bit is the borrow.
    assign trial = {rem_q, quot_q[XLEN-1]} - {1'b0, divisor_q};

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!op_is_div) begin
                        state_d = S_MUL;
                    end else if (div_fast) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL:  state_d = S_DONE;
            S_DIV:  state_d = (cnt_q == LAST) ? S_FIX : S_DIV;
            S_FIX:  state_d = S_DONE;
            S_DONE: state_d = bus.result_ready ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
        if (bus.flush && !is_idle) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        bus.start_ready  = is_idle;
        bus.busy         = !is_idle;
        bus.result_valid = (state_q == S_DONE);
    end

    assign bus.result = result_q;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign mul_sn     = mul_sn_q;

    always_comb begin
        op_d      = op_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        mul_sn_d  = mul_sn_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        neg_q_d   = neg_q_q;
        neg_r_d   = neg_r_q;
        fast_d    = fast_q;

        if (accept) begin
            op_d      = bus.funct3;
            mul_a_d   = bus.rs1;
            mul_b_d   = bus.rs2;
            mul_sn_d  = sn_for(bus.funct3);
            quot_d    = cond_neg(bus.rs1, div_signed && (rs1_s < 0));
            divisor_d = cond_neg(bus.rs2, div_signed && (rs2_s < 0));
            neg_q_d   = div_signed && (bus.rs1[XLEN-1] ^ bus.rs2[XLEN-1]);
            neg_r_d   = div_signed && bus.rs1[XLEN-1];
            cnt_d     = '0;
            fast_d    = div_fast;
            // A fast-path divide parks its answer in the remainder register and
            // spends one cycle in FIX so every divide writes back from the same place.
            rem_d     = div_fast ? fast_result(bus.funct3, bus.rs1, div_by_zero) : '0;
        end

        case (state_q)
            S_MUL: begin
                result_d = (op_q[1:0] == 2'b00) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];
            end
            S_DIV: begin
                cnt_d = cnt_q + CW'(1);
                if (!trial[XLEN]) begin
                    rem_d  = trial[XLEN-1:0];
                    quot_d = {quot_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d  = {rem_q[XLEN-2:0], quot_q[XLEN-1]};
                    quot_d = {quot_q[XLEN-2:0], 1'b0};
                end
            end
            S_FIX: begin
                if (fast_q) begin
                    result_d = rem_q;
                end else if (op_q[1]) begin
                    result_d = cond_neg(rem_q, neg_r_q);
                end else begin
                    result_d = cond_neg(quot_q, neg_q_q);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            mul_sn_q  <= 2'b00;
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            fast_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            mul_sn_q  <= mul_sn_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            neg_q_q   <= neg_q_d;
            neg_r_q   <= neg_r_d;
            fast_q    <= fast_d;
        end
    end
endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Self-checking bench for mdu_seq_ctrl: directed RV32M cases, randomized ops against
// an arithmetic reference model, back-pressure, flush and asynchronous reset.
`timescale 1ns/1ps
module tb_mdu_seq_ctrl;
    localparam int XLEN = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [XLEN-1:0]   mul_a, mul_b;
    logic [1:0]        mul_sn;
    logic [2*XLEN-1:0] mul_p;
    logic [2*XLEN-1:0] ext_a, ext_b;
    int                checks = 0;
    int                errors = 0;

    mdu_seq_ctrl_if #(.XLEN(XLEN)) bus ();

    mdu_seq_ctrl #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .mul_a  (mul_a),
        .mul_b  (mul_b),
        .mul_sn (mul_sn),
        .mul_p  (mul_p)
    );

    always #5 clk = ~clk;

    // Stand-in for the combinational array multiplier.
    assign ext_a = mul_sn[1] ? {{XLEN{mul_a[XLEN-1]}}, mul_a} : {{XLEN{1'b0}}, mul_a};
    assign ext_b = mul_sn[0] ? {{XLEN{mul_b[XLEN-1]}}, mul_b} : {{XLEN{1'b0}}, mul_b};
    assign mul_p = ext_a * ext_b;

    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, p;
        longint unsigned ua, ub, up;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                up = ua / ub; return up[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                up = ua % ub; return up[31:0];
            end
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return 1;
        if (b == 0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    function automatic logic [1:0] exp_sn(input logic [2:0] f3);
        if (f3 == 3'd2) return 2'b10;
        if (f3 == 3'd3) return 2'b00;
        return 2'b11;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, wait (bounded) for the result, consume it. lat counts edges after the accept edge.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output logic [1:0] sn);
        @(negedge clk);
        bus.funct3      = f3;
        bus.rs1         = a;
        bus.rs2         = b;
        bus.start_valid = 1'b1;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        bus.rs1         = $urandom;
        bus.rs2         = $urandom;
        bus.funct3      = 3'($urandom_range(0, 7));
        sn  = mul_sn;
        lat = 0;
        while (bus.result_valid !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus.result;
        bus.result_ready = 1'b1;
        @(posedge clk); #1;
        bus.result_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({bus.result_valid, bus.busy, bus.start_ready} !== 3'b001) begin
            errors++;
            $display("FAIL reset_ctrl got valid/busy/ready=%b want 001", {bus.result_valid, bus.busy, bus.start_ready});
        end
        checks++;
        if (bus.result !== 32'h0) begin
            errors++;
            $display("FAIL reset_result got %h want 00000000", bus.result);
        end
        checks++;
        if ({mul_a, mul_b, mul_sn} !== '0) begin
            errors++;
            $display("FAIL reset_mul_ports got a=%h b=%h sn=%b want zeros", mul_a, mul_b, mul_sn);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.start_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got ready=%b busy=%b want 1 0", bus.start_ready, bus.busy);
        end
    endtask

    task automatic test_mul_directed();
        logic [2:0]  f3s [4];
        logic [31:0] as [4], bs [4], want [4];
        logic [1:0]  sns [4];
        logic [31:0] res;
        int          lat;
        logic [1:0]  sn;
        f3s  = '{3'd0, 3'd1, 3'd2, 3'd3};
        as   = '{32'h7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        bs   = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        want = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        sns  = '{2'b11, 2'b11, 2'b10, 2'b00};
        for (int i = 0; i < 4; i++) begin
            run_op(f3s[i], as[i], bs[i], res, lat, sn);
            checks++;
            if (res !== want[i]) begin
                errors++;
                $display("FAIL mul_result[%0d] got %h want %h", i, res, want[i]);
            end
            checks++;
            if (lat != 1) begin
                errors++;
                $display("FAIL mul_latency[%0d] got %0d want 1", i, lat);
            end
            checks++;
            if (sn !== sns[i]) begin
                errors++;
                $display("FAIL mul_sn[%0d] got %b want %b", i, sn, sns[i]);
            end
        end
    endtask

    task automatic test_div_directed();
        logic [2:0]  f3s [8];
        logic [31:0] as [8], bs [8], want [8];
        int          lats [8];
        logic [31:0] res;
        int          lat;
        logic [1:0]  sn;
        f3s  = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
        as   = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        bs   = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        want = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
        lats = '{33, 33, 33, 33, 1, 1, 1, 1};
        for (int i = 0; i < 8; i++) begin
            run_op(f3s[i], as[i], bs[i], res, lat, sn);
            checks++;
            if (res !== want[i]) begin
                errors++;
                $display("FAIL div_result[%0d] got %h want %h", i, res, want[i]);
            end
            checks++;
            if (lat != lats[i]) begin
                errors++;
                $display("FAIL div_latency[%0d] got %0d want %0d", i, lat, lats[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b, res, want;
        int          lat, wl;
        logic [1:0]  sn;
        for (int i = 0; i < 150; i++) begin
            f3   = 3'($urandom_range(0, 7));
            a    = pick_operand();
            b    = pick_operand();
            want = ref_op(f3, a, b);
            wl   = exp_latency(f3, a, b);
            run_op(f3, a, b, res, lat, sn);
            checks++;
            if (res !== want || lat != wl) begin
                errors++;
                $display("FAIL random[%0d] f3=%0d a=%h b=%h got %h lat %0d want %h lat %0d",
                         i, f3, a, b, res, lat, want, wl);
            end
            checks++;
            if (sn === 2'b01 || (!f3[2] && sn !== exp_sn(f3))) begin
                errors++;
                $display("FAIL random_sn[%0d] f3=%0d got %b want %b", i, f3, sn, exp_sn(f3));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, held, a2, b2;
        int          n;
        a = $urandom; b = $urandom;
        a2 = $urandom; b2 = 32'($urandom_range(1, 1000));
        @(negedge clk);
        bus.funct3 = 3'd3; bus.rs1 = a; bus.rs2 = b; bus.start_valid = 1'b1;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        n = 0;
        while (bus.result_valid !== 1'b1 && n < 60) begin @(posedge clk); #1; n++; end
        held = bus.result;
        checks++;
        if (held !== ref_op(3'd3, a, b)) begin
            errors++;
            $display("FAIL bp_result got %h want %h", held, ref_op(3'd3, a, b));
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.result_valid !== 1'b1 || bus.result !== held || bus.start_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d] got valid=%b result=%h ready=%b want 1 %h 0",
                         i, bus.result_valid, bus.result, bus.start_ready, held);
            end
        end
        @(negedge clk);
        bus.result_ready = 1'b1;
        bus.funct3 = 3'd5; bus.rs1 = a2; bus.rs2 = b2; bus.start_valid = 1'b1;
        @(posedge clk); #1;
        bus.result_ready = 1'b0;
        checks++;
        if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0 || bus.start_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got valid=%b busy=%b ready=%b want 0 0 1",
                     bus.result_valid, bus.busy, bus.start_ready);
        end
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_next_accept got busy=%b want 1", bus.busy);
        end
        n = 0;
        while (bus.result_valid !== 1'b1 && n < 60) begin @(posedge clk); #1; n++; end
        checks++;
        if (bus.result !== ref_op(3'd5, a2, b2) || n != XLEN + 1) begin
            errors++;
            $display("FAIL bp_next_result got %h lat %0d want %h lat %0d", bus.result, n, ref_op(3'd5, a2, b2), XLEN + 1);
        end
        bus.result_ready = 1'b1;
        @(posedge clk); #1;
        bus.result_ready = 1'b0;
    endtask

    task automatic test_flush();
        int seen;
        @(negedge clk);
        bus.funct3 = 3'd4; bus.rs1 = $urandom; bus.rs2 = $urandom | 32'h1; bus.start_valid = 1'b1;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0 || bus.start_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_div got busy=%b valid=%b ready=%b want 0 0 1", bus.busy, bus.result_valid, bus.start_ready);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.result_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_no_result got %0d valid cycles want 0", seen);
        end
        @(negedge clk);
        bus.flush = 1'b1; bus.start_valid = 1'b1; bus.funct3 = 3'd0;
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.start_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_blocks_accept got busy=%b want 0", bus.busy);
        end
        @(negedge clk);
        bus.funct3 = 3'd0; bus.rs1 = 32'd3; bus.rs2 = 32'd4; bus.start_valid = 1'b1;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_done got busy=%b valid=%b want 0 0", bus.busy, bus.result_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int          lat;
        logic [1:0]  sn;
        @(negedge clk);
        bus.funct3 = 3'd7; bus.rs1 = $urandom; bus.rs2 = 32'($urandom_range(1, 500)); bus.start_valid = 1'b1;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.result_valid, bus.busy, bus.start_ready} !== 3'b001 ||
            bus.result !== 32'h0 || {mul_a, mul_b, mul_sn} !== '0) begin
            errors++;
            $display("FAIL reset_mid got valid=%b busy=%b ready=%b result=%h a=%h b=%h sn=%b want 0 0 1 and zeros",
                     bus.result_valid, bus.busy, bus.start_ready, bus.result, mul_a, mul_b, mul_sn);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.start_ready !== 1'b1 || bus.result_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_release got ready=%b valid=%b want 1 0", bus.start_ready, bus.result_valid);
        end
        run_op(3'd6, 32'hFFFF_FF9C, 32'd7, res, lat, sn);
        checks++;
        if (res !== ref_op(3'd6, 32'hFFFF_FF9C, 32'd7) || lat != XLEN + 1) begin
            errors++;
            $display("FAIL reset_mid_after got %h lat %0d want %h lat %0d", res, lat, ref_op(3'd6, 32'hFFFF_FF9C, 32'd7), XLEN + 1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        bus.start_valid  = 1'b0;
        bus.funct3       = 3'd0;
        bus.rs1          = '0;
        bus.rs2          = '0;
        bus.flush        = 1'b0;
        bus.result_ready = 1'b0;
        test_reset();
        test_mul_directed();
        test_div_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
